axi_to_wb_data_channel: RTL
===========================

// Module: axi_to_wb_data_channel
// PURPOSE
//  AXI-slave-side data-channel engine: the responder counterpart of the WB->AXI initiator data path.
//  Accepts AXI W beats and forwards each one to the Wishbone master as a write beat.
//  Returns Wishbone read data to AXI as R beats.
//  Sits in the AXI->WB bridge, behind the AW/AR address decoder, which issues one command per burst.
// PARAMETERS
//  DATA_WIDTH  32      data bus width, multiple of 8; STRB_W = DATA_WIDTH/8
//  ID_WIDTH    4       AXI ID width (R channel only)
//  CHANNEL     "READ"  "READ" = R-channel engine; "WRITE" = W-channel engine
// PORTS
//  ACLK        in   1        clock
//  ARESETN     in   1        asynchronous active-low reset
//  cmd_valid   in   1        burst command from address decoder
//  cmd_ready   out  1        engine idle, command accepted when valid&ready
//  cmd_len     in   8        AXI LEN; beats = cmd_len+1
//  cmd_id      in   ID_WIDTH burst ID (READ only)
//  beat_req    out  1        request one WB beat; held until beat_ack or beat_err
//  beat_ack    in   1        WB beat completed OK
//  beat_err    in   1        WB beat completed with error
//  wb_dat_i    in   DATA_W   WB read data, valid with ack/err
//  wb_dat_o    out  DATA_W   WB write data
//  wb_sel_o    out  STRB_W   WB byte select
//  s_wdata     in   DATA_W   AXI W data
//  s_wstrb     in   STRB_W   AXI W strobes
//  s_wlast     in   1        AXI W last
//  s_wvalid    in   1        AXI W valid
//  s_wready    out  1        AXI W ready
//  s_rdata     out  DATA_W   AXI R data
//  s_rresp     out  2        AXI R response: 00 OKAY, 10 SLVERR
//  s_rid       out  ID_WIDTH AXI R ID
//  s_rlast     out  1        AXI R last
//  s_rvalid    out  1        AXI R valid
//  s_rready    in   1        AXI R ready
//  done        out  1        1-cycle pulse when the burst is complete
//  done_resp   out  2        OKAY, or SLVERR if any beat erred or WLAST mismatched (WRITE)
// BEHAVIOUR
//  - Reset: every output is 0 except cmd_ready=1; state=IDLE; beat counter, ID and response
//    registers cleared. Reset mid-burst abandons the burst; no done pulse is issued.
//  - All outputs are registered, except cmd_ready = (state==IDLE).
//  - Beat counter: 8 bits, cleared on cmd accept. Final beat when cnt==len_q. len=255 gives 256 beats, no wrap.
//  - WRITE FSM: IDLE -> W_ACC on cmd accept.
//    W_ACC: s_wready=1. On wvalid: latch data/strb into wb_dat_o/wb_sel_o, drop s_wready, go W_WB.
//    W_WB: beat_req=1. On ack|err: beat_req=0, cnt++. If final beat -> W_DONE, else -> W_ACC.
//    W_DONE: done=1 for 1 cycle -> IDLE.
//    Throughput: 1 beat per 2+WB-latency cycles minimum; no overlap of AXI accept and WB beat.
//    WLAST check per beat: wlast must equal (cnt==len_q). A mismatch sets the sticky SLVERR.
//    The burst still runs exactly len+1 beats. Extra W beats after the burst are not accepted.
//  - READ FSM: IDLE -> R_WB on cmd accept; s_rid <= cmd_id.
//    R_WB: beat_req=1. On ack|err: latch wb_dat_i into s_rdata; rresp = err?SLVERR:OKAY;
//    s_rlast = (cnt==len_q); s_rvalid=1; go R_RESP.
//    R_RESP: hold rdata/rresp/rlast/rvalid stable while !s_rready.
//    On s_rready: s_rvalid=0, cnt++. If last -> R_DONE, else -> R_WB.
//    R_DONE: done pulse -> IDLE.
//  - beat_ack and beat_err asserted together: err wins.
//    ack|err while beat_req=0: ignored.
//  - done_resp accumulates the per-beat errors (sticky), valid with done, cleared on the next cmd accept.
//  - Unused channel outputs are tied 0: READ ties s_wready, wb_dat_o and wb_sel_o;
//    WRITE ties s_r* outputs. In WRITE mode done_resp drives the B-channel response.
//  - cmd_valid while busy: cmd_ready=0, command held off; no queueing.
// STRUCTURE
//  - Shared package / header: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, FSM state encodings,
//    CHANNEL string constants (shared with the WB->AXI data channel).
//  - Single module with two generate branches (gen_read, gen_write); no sub-module.
//    The beat counter and last-detect logic is inline in each branch.
// TESTING
//  - WRITE len=0: cmd_len=0, W beat 0xDEADBEEF, strb=0xF, wlast=1, WB ack after 2 cycles
//    -> wb_dat_o=0xDEADBEEF, wb_sel_o=0xF, done with done_resp=OKAY.
//  - WRITE len=3, beat 2 gets beat_err
//    -> 4 WB beats issued, done_resp=SLVERR; wlast early at beat 1 also -> SLVERR, still 4 beats.
//  - READ len=3, id=5, WB returns 0x10..0x13, s_rready toggling 1/0
//    -> R beats 0x10..0x13 in order, s_rid=5, rlast on the 4th beat only, data stable while stalled.
//  - READ beat_ack and beat_err together on beat 0 -> s_rresp=SLVERR; len=255 -> exactly 256 R beats, rlast on the last.
//  - ARESETN low during R_RESP with s_rvalid=1 -> s_rvalid=0 immediately, cmd_ready=1, no done;
//    the next burst runs cleanly.
//  - cmd_valid held while busy -> cmd_ready=0 until done+1 cycle, then accepted.

Source files
------------

// File: rtl/axi_to_wb_data_channel_pkg.sv
// Constants shared by the AXI<->WB bridge data-channel engines: response codes,
// channel selectors and the data-channel FSM state encoding.
package axi_to_wb_data_channel_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam string CHAN_READ  = "READ";
  localparam string CHAN_WRITE = "WRITE";

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_ACC,
    ST_W_WB,
    ST_W_DONE,
    ST_R_WB,
    ST_R_RESP,
    ST_R_DONE
  } dc_state_e;

endpackage

// File: rtl/axi_to_wb_data_channel.sv
// AXI-slave data-channel engine: forwards AXI W beats to Wishbone write beats
// (WRITE) or returns Wishbone read data as AXI R beats (READ), one burst per command.
module axi_to_wb_data_channel
  import axi_to_wb_data_channel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter string       CHANNEL    = "READ",
  localparam int unsigned STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  output logic                  beat_req,
  input  logic                  beat_ack,
  input  logic                  beat_err,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [STRB_W-1:0]     wb_sel_o,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_W-1:0]     s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  done,
  output logic [1:0]            done_resp
);

  if (CHANNEL == CHAN_READ) begin : gen_read
    dc_state_e  state;
    logic [7:0] cnt;
    logic [7:0] len_q;
    logic       last_beat;
    logic       unused_w;

    assign last_beat = (cnt == len_q);
    assign cmd_ready = (state == ST_IDLE);
    assign s_wready  = 1'b0;
    assign wb_dat_o  = '0;
    assign wb_sel_o  = '0;
    assign unused_w  = ^{s_wdata, s_wstrb, s_wlast, s_wvalid};

    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        state     <= ST_IDLE;
        cnt       <= '0;
        len_q     <= '0;
        beat_req  <= 1'b0;
        s_rdata   <= '0;
        s_rresp   <= RESP_OKAY;
        s_rid     <= '0;
        s_rlast   <= 1'b0;
        s_rvalid  <= 1'b0;
        done      <= 1'b0;
        done_resp <= RESP_OKAY;
      end else begin
        done <= 1'b0;
        case (state)
          ST_IDLE: if (cmd_valid) begin
            len_q     <= cmd_len;
            cnt       <= '0;
            s_rid     <= cmd_id;
            done_resp <= RESP_OKAY;
            beat_req  <= 1'b1;
            state     <= ST_R_WB;
          end
          ST_R_WB: if (beat_ack || beat_err) begin
            // err takes precedence when the slave raises both
            beat_req <= 1'b0;
            s_rdata  <= wb_dat_i;
            s_rresp  <= beat_err ? RESP_SLVERR : RESP_OKAY;
            s_rlast  <= last_beat;
            s_rvalid <= 1'b1;
            if (beat_err) done_resp <= RESP_SLVERR;
            state    <= ST_R_RESP;
          end
          ST_R_RESP: if (s_rready) begin
            s_rvalid <= 1'b0;
            cnt      <= cnt + 8'd1;
            if (s_rlast) begin
              done  <= 1'b1;
              state <= ST_R_DONE;
            end else begin
              beat_req <= 1'b1;
              state    <= ST_R_WB;
            end
          end
          ST_R_DONE: state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end else begin : gen_write
    dc_state_e  state;
    logic [7:0] cnt;
    logic [7:0] len_q;
    logic       last_beat;
    logic       unused_r;

    assign last_beat = (cnt == len_q);
    assign cmd_ready = (state == ST_IDLE);
    assign s_rdata   = '0;
    assign s_rresp   = RESP_OKAY;
    assign s_rid     = '0;
    assign s_rlast   = 1'b0;
    assign s_rvalid  = 1'b0;
    assign unused_r  = ^{cmd_id, wb_dat_i, s_rready};

    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        state     <= ST_IDLE;
        cnt       <= '0;
        len_q     <= '0;
        beat_req  <= 1'b0;
        wb_dat_o  <= '0;
        wb_sel_o  <= '0;
        s_wready  <= 1'b0;
        done      <= 1'b0;
        done_resp <= RESP_OKAY;
      end else begin
        done <= 1'b0;
        case (state)
          ST_IDLE: if (cmd_valid) begin
            len_q     <= cmd_len;
            cnt       <= '0;
            done_resp <= RESP_OKAY;
            s_wready  <= 1'b1;
            state     <= ST_W_ACC;
          end
          ST_W_ACC: if (s_wvalid) begin
            // WLAST mismatch is flagged but the burst still runs len+1 beats
            wb_dat_o <= s_wdata;
            wb_sel_o <= s_wstrb;
            s_wready <= 1'b0;
            beat_req <= 1'b1;
            if (s_wlast != last_beat) done_resp <= RESP_SLVERR;
            state    <= ST_W_WB;
          end
          ST_W_WB: if (beat_ack || beat_err) begin
            beat_req <= 1'b0;
            cnt      <= cnt + 8'd1;
            if (beat_err) done_resp <= RESP_SLVERR;
            if (last_beat) begin
              done  <= 1'b1;
              state <= ST_W_DONE;
            end else begin
              s_wready <= 1'b1;
              state    <= ST_W_ACC;
            end
          end
          ST_W_DONE: state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
